// File: rtl/vint_gen.sv
// vint_gen: raster counters with a one-cycle video interrupt at a programmed line/position.
// Define VINT_HPOS_EN to add the HPOSW port and a programmable horizontal match position.
module vint_gen #(
  parameter int HTOTAL = 512,
  parameter int VTOTAL = 312
) (
  input  logic       CLK,
  input  logic       RES,
  input  logic [7:0] WD,
  input  logic       LINTL,
  input  logic       LINTH,
`ifdef VINT_HPOS_EN
  input  logic       HPOSW,
`endif
  output logic       VINTv,
  output logic [9:0] HCNT,
  output logic [8:0] VCNT,
  output logic       LSTART,
  output logic       FSTART
);
  logic [8:0] intline;
  logic       inten;
  logic [9:0] hpos;
  logic       hwrap, vwrap, unused_wd;
  assign hwrap     = HCNT == 10'(HTOTAL - 1);
  assign vwrap     = VCNT == 9'(VTOTAL - 1);
  assign LSTART    = HCNT == '0;
  assign FSTART    = LSTART && VCNT == '0;
  assign unused_wd = ^WD;
  always_ff @(posedge CLK) begin
    if (RES) begin
      HCNT    <= '0;
      VCNT    <= '0;
      intline <= '0;
      inten   <= 1'b0;
      VINTv   <= 1'b0;
    end else begin
      HCNT <= hwrap ? '0 : HCNT + 10'd1;
      if (hwrap) VCNT <= vwrap ? '0 : VCNT + 9'd1;
      if (LINTL) intline[7:0] <= WD;
      if (LINTH) begin
        intline[8] <= WD[0];
        inten      <= WD[7];
      end
      // Out-of-range intline/hpos simply never equal the counters.
      VINTv <= inten && VCNT == intline && HCNT == hpos;
    end
  end
`ifdef VINT_HPOS_EN
  always_ff @(posedge CLK) begin
    if (RES) hpos <= '0;
    else if (HPOSW) hpos <= LINTH ? {WD[2:1], hpos[7:0]} : {hpos[9:8], WD};
  end
`else
  assign hpos = '0;
`endif
endmodule

// File: tb/tb_vint_gen.sv
// tb_vint_gen: directed checks of raster wrap, line interrupt, coincident writes and reset.
module tb_vint_gen;
  localparam int H = 8, V = 200, F = H * V;
  logic       CLK = 1'b0, RES = 1'b1, LINTL = 1'b0, LINTH = 1'b0;
  logic [7:0] WD = '0;
  logic       VINTv, LSTART, FSTART;
  logic [9:0] HCNT;
  logic [8:0] VCNT;
  int checks = 0, failures = 0;
  int cnt, lh, lv, fcnt;
`ifdef VINT_HPOS_EN
  logic HPOSW = 1'b0;
`endif
  always #5 CLK = ~CLK;
  vint_gen #(.HTOTAL(H), .VTOTAL(V)) dut (
    .CLK(CLK), .RES(RES), .WD(WD), .LINTL(LINTL), .LINTH(LINTH),
`ifdef VINT_HPOS_EN
    .HPOSW(HPOSW),
`endif
    .VINTv(VINTv), .HCNT(HCNT), .VCNT(VCNT), .LSTART(LSTART), .FSTART(FSTART)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  task automatic wr(input logic l, input logic h, input logic [7:0] d);
    LINTL = l;
    LINTH = h;
    WD    = d;
    step();
    LINTL = 1'b0;
    LINTH = 1'b0;
  endtask
  task automatic run(input int n, output int c, output int ph, output int pv);
    c  = 0;
    ph = -1;
    pv = -1;
    repeat (n) begin
      step();
      if (VINTv) begin
        c++;
        ph = int'(HCNT);
        pv = int'(VCNT);
      end
    end
  endtask
  task automatic wait_at(input int h, input int v);
    int k = 0;
    while (!(int'(HCNT) == h && int'(VCNT) == v) && k < 2 * F) begin
      step();
      k++;
    end
    check("wait_in_budget", k < 2 * F, 1);
  endtask
  initial begin
    repeat (3) step();
    RES = 1'b0;
    check("rst_hcnt", HCNT, 0);
    check("rst_vcnt", VCNT, 0);
    check("rst_vint", VINTv, 0);
    check("rst_lstart", LSTART, 1);
    check("rst_fstart", FSTART, 1);
    fcnt = 0;
    cnt  = 0;
    for (int i = 1; i <= F; i++) begin
      step();
      if (FSTART) fcnt++;
      if (VINTv) cnt++;
      if (i == H - 1) check("line_end_h", HCNT, H - 1);
      if (i == H) begin
        check("line_wrap_h", HCNT, 0);
        check("line_wrap_v", VCNT, 1);
        check("lstart_wrap", LSTART, 1);
      end
      if (i == F - 1) begin
        check("frame_end_h", HCNT, H - 1);
        check("frame_end_v", VCNT, V - 1);
      end
    end
    check("frame_wrap_h", HCNT, 0);
    check("frame_wrap_v", VCNT, 0);
    check("fstart_once", fcnt, 1);
    check("no_vint_disabled", cnt, 0);
    wr(1, 0, 8'h64);
    wr(0, 1, 8'h80);
    run(2 * F, cnt, lh, lv);
    check("hit100_count", cnt, 2);
    check("hit100_h", lh, 1);
    check("hit100_v", lv, 100);
    wait_at(0, 100);
    wr(1, 0, 8'h65);
    check("coinc_vint", VINTv, 1);
    check("coinc_v", VCNT, 100);
    run(F, cnt, lh, lv);
    check("coinc_next_count", cnt, 1);
    check("coinc_next_v", lv, 101);
    wait_at(0, 101);
    wr(0, 1, 8'h00);
    check("disable_inflight", VINTv, 1);
    step();
    check("disable_one_wide", VINTv, 0);
    run(F, cnt, lh, lv);
    check("disable_count", cnt, 0);
    wr(0, 1, 8'h80);
    wait_at(0, 101);
    RES = 1'b1;
    step();
    check("midrst_vint", VINTv, 0);
    check("midrst_h", HCNT, 0);
    check("midrst_v", VCNT, 0);
    LINTL = 1'b1;
    LINTH = 1'b1;
    WD    = 8'h80;
    step();
    LINTL = 1'b0;
    LINTH = 1'b0;
    RES   = 1'b0;
    run(F, cnt, lh, lv);
    check("rst_blocks_write", cnt, 0);
    wr(1, 1, 8'h82);
    run(F, cnt, lh, lv);
    check("both_count", cnt, 1);
    check("both_v", lv, 130);
    check("both_h", lh, 1);
    wr(1, 0, 8'hC8);
    run(F, cnt, lh, lv);
    check("line_vtotal_count", cnt, 0);
    wr(1, 0, 8'hC7);
    run(F, cnt, lh, lv);
    check("line_last_count", cnt, 1);
    check("line_last_v", lv, V - 1);
    wr(1, 0, 8'h00);
    run(F, cnt, lh, lv);
    check("line0_count", cnt, 1);
    check("line0_v", lv, 0);
    check("line0_h", lh, 1);
    wr(1, 0, 8'h90);
    wr(0, 1, 8'h81);
    run(2 * F, cnt, lh, lv);
    check("oor400_count", cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
